// File: rtl/ann_pkg.sv
// Shared constants for the layer-one stream loader and neuron FSM:
// command codes, memory region bases and the loader state encoding.
package ann_pkg;

    localparam logic [7:0] CMD_IMAGE  = 8'hA1;
    localparam logic [7:0] CMD_PARAMS = 8'hA2;
    localparam logic [7:0] CMD_ALL    = 8'hA3;

    localparam int INPUT_BASE  = 0;
    localparam int BIAS_BASE   = 784;
    localparam int WEIGHT_BASE = 800;

    typedef enum logic [2:0] {
        ST_WAIT_CMD,
        ST_LOAD_PARAMS,
        ST_LOAD_IMAGE,
        ST_CHECK,
        ST_START,
        ST_WAIT_DONE
    } state_t;

endpackage

// File: rtl/ann_frame_checksum.sv
// Additive 8-bit frame checksum: cleared per frame, accumulates payload
// bytes, and compares the running sum against a candidate checksum byte.
module ann_frame_checksum (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clear,
    input  logic       acc_en,
    input  logic [7:0] acc_data,
    input  logic [7:0] cmp_data,
    output logic [7:0] sum,
    output logic       match
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum <= 8'd0;
        end else if (clear) begin
            sum <= 8'd0;
        end else if (acc_en) begin
            sum <= sum + acc_data;
        end
    end

    assign match = (sum == cmp_data);

endmodule

// File: rtl/ann_stream_loader.sv
// Stream front end for layer one: writes image/params frames into the
// shared byte memory, verifies the checksum, then starts the layer.
module ann_stream_loader #(
    parameter int N           = 784,
    parameter int M           = 16,
    parameter int ADDR_WIDTH  = 14,
    parameter int INPUT_BASE  = ann_pkg::INPUT_BASE,
    parameter int BIAS_BASE   = ann_pkg::BIAS_BASE,
    parameter int WEIGHT_BASE = ann_pkg::WEIGHT_BASE
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  s_valid,
    input  logic [7:0]            s_data,
    output logic                  s_ready,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_waddr,
    output logic [7:0]            mem_wdata,
    output logic                  layer_start,
    input  logic                  layer_done,
    output logic                  busy,
    output logic                  params_valid,
    output logic                  frame_err,
    output logic                  run_done
);

    import ann_pkg::*;

    localparam int          P_LEN  = M + M * N;
    localparam logic [13:0] P_LAST = 14'(P_LEN - 1);
    localparam logic [13:0] I_LAST = 14'(N - 1);

    state_t                state;
    logic [7:0]            cmd;
    logic [13:0]           cnt;
    logic                  accept;
    logic                  sum_clear;
    logic                  sum_en;
    logic                  sum_match;
    logic [7:0]            sum;
    logic [ADDR_WIDTH-1:0] p_addr;
    logic [ADDR_WIDTH-1:0] i_addr;

    assign accept = s_valid && s_ready;
    assign busy   = (state != ST_WAIT_CMD);

    assign sum_clear = accept && (state == ST_WAIT_CMD);
    assign sum_en    = accept && ((state == ST_LOAD_PARAMS) ||
                                  (state == ST_LOAD_IMAGE));

    // Bias and weight regions are contiguous, so one run covers both.
    assign p_addr = ADDR_WIDTH'(BIAS_BASE) + ADDR_WIDTH'(cnt);
    assign i_addr = ADDR_WIDTH'(INPUT_BASE) + ADDR_WIDTH'(cnt);

    ann_frame_checksum u_checksum (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (sum_clear),
        .acc_en   (sum_en),
        .acc_data (s_data),
        .cmp_data (s_data),
        .sum      (sum),
        .match    (sum_match)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_WAIT_CMD;
            cmd          <= 8'd0;
            cnt          <= 14'd0;
            s_ready      <= 1'b0;
            mem_we       <= 1'b0;
            mem_waddr    <= '0;
            mem_wdata    <= 8'd0;
            layer_start  <= 1'b0;
            params_valid <= 1'b0;
            frame_err    <= 1'b0;
            run_done     <= 1'b0;
        end else begin
            mem_we      <= 1'b0;
            layer_start <= 1'b0;
            frame_err   <= 1'b0;
            run_done    <= 1'b0;
            unique case (state)
                ST_WAIT_CMD: begin
                    s_ready <= 1'b1;
                    if (accept) begin
                        cnt <= 14'd0;
                        cmd <= s_data;
                        unique case (1'b1)
                            (s_data == CMD_IMAGE): begin
                                state <= ST_LOAD_IMAGE;
                            end
                            (s_data == CMD_PARAMS),
                            (s_data == CMD_ALL): begin
                                params_valid <= 1'b0;
                                state        <= ST_LOAD_PARAMS;
                            end
                            default: begin
                                frame_err <= 1'b1;
                            end
                        endcase
                    end
                end
                ST_LOAD_PARAMS: begin
                    if (accept) begin
                        mem_we    <= 1'b1;
                        mem_waddr <= p_addr;
                        mem_wdata <= s_data;
                        if (cnt == P_LAST) begin
                            cnt   <= 14'd0;
                            state <= (cmd == CMD_ALL) ? ST_LOAD_IMAGE
                                                      : ST_CHECK;
                        end else begin
                            cnt <= cnt + 14'd1;
                        end
                    end
                end
                ST_LOAD_IMAGE: begin
                    if (accept) begin
                        mem_we    <= 1'b1;
                        mem_waddr <= i_addr;
                        mem_wdata <= s_data;
                        if (cnt == I_LAST) begin
                            cnt   <= 14'd0;
                            state <= ST_CHECK;
                        end else begin
                            cnt <= cnt + 14'd1;
                        end
                    end
                end
                ST_CHECK: begin
                    if (accept) begin
                        if (!sum_match) begin
                            frame_err <= 1'b1;
                            state     <= ST_WAIT_CMD;
                        end else if (cmd == CMD_PARAMS) begin
                            params_valid <= 1'b1;
                            state        <= ST_WAIT_CMD;
                        end else if (cmd == CMD_ALL || params_valid) begin
                            if (cmd == CMD_ALL) begin
                                params_valid <= 1'b1;
                            end
                            layer_start <= 1'b1;
                            s_ready     <= 1'b0;
                            state       <= ST_START;
                        end else begin
                            frame_err <= 1'b1;
                            state     <= ST_WAIT_CMD;
                        end
                    end
                end
                ST_START: begin
                    state <= ST_WAIT_DONE;
                end
                ST_WAIT_DONE: begin
                    if (layer_done) begin
                        run_done <= 1'b1;
                        s_ready  <= 1'b1;
                        state    <= ST_WAIT_CMD;
                    end
                end
                default: begin
                    state <= ST_WAIT_CMD;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ann_stream_loader.sv
// Self-checking bench for ann_stream_loader: random frames against an
// address/data/timing model derived from the frame format.
module tb_ann_stream_loader;

    localparam int N  = 784;
    localparam int M  = 16;
    localparam int AW = 14;
    localparam int IB = 0;
    localparam int BB = 784;
    localparam int WB = 800;
    localparam int PL = M + M * N;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          s_valid = 1'b0;
    logic [7:0]    s_data = 8'd0;
    logic          s_ready;
    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic [7:0]    mem_wdata;
    logic          layer_start;
    logic          layer_done = 1'b0;
    logic          busy;
    logic          params_valid;
    logic          frame_err;
    logic          run_done;

    always #5 clk = ~clk;

    ann_stream_loader #(
        .N           (N),
        .M           (M),
        .ADDR_WIDTH  (AW),
        .INPUT_BASE  (IB),
        .BIAS_BASE   (BB),
        .WEIGHT_BASE (WB)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .s_valid      (s_valid),
        .s_data       (s_data),
        .s_ready      (s_ready),
        .mem_we       (mem_we),
        .mem_waddr    (mem_waddr),
        .mem_wdata    (mem_wdata),
        .layer_start  (layer_start),
        .layer_done   (layer_done),
        .busy         (busy),
        .params_valid (params_valid),
        .frame_err    (frame_err),
        .run_done     (run_done)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int n_start = 0;
    int n_err = 0;
    int n_done = 0;
    int start_cyc = -1;
    int err_cyc = -1;
    int done_cyc = -1;
    bit abort = 1'b0;
    int last_cyc;
    int sum_cyc;

    logic [AW-1:0] wa_q[$];
    logic [7:0]    wd_q[$];
    int            wc_q[$];
    logic [7:0]    pl[$];
    int            pay_cyc[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (layer_start) begin
            n_start++;
            start_cyc = cyc;
        end
        if (frame_err) begin
            n_err++;
            err_cyc = cyc;
        end
        if (run_done) begin
            n_done++;
            done_cyc = cyc;
        end
        if (mem_we) begin
            wa_q.push_back(mem_waddr);
            wd_q.push_back(mem_wdata);
            wc_q.push_back(cyc);
        end
    end

    initial begin
        repeat (95000) @(posedge clk);
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    // Memory location of payload byte j, from the frame layout.
    function automatic int exp_addr(input logic [7:0] cmd, input int j);
        int n;
        int i;
        if (cmd == 8'hA1) return IB + j;
        if (j < M) return BB + j;
        if (j < PL) begin
            n = (j - M) / N;
            i = (j - M) % N;
            return WB + n * N + i;
        end
        return IB + (j - PL);
    endfunction

    function automatic int first_bad_write(input logic [7:0] cmd);
        for (int k = 0; k < pl.size(); k++) begin
            if (k >= wa_q.size()) return k;
            if (int'(wa_q[k]) != exp_addr(cmd, k)) return k;
            if (wd_q[k] != pl[k]) return k;
            if (wc_q[k] != pay_cyc[k] + 1) return k;
        end
        return -1;
    endfunction

    function automatic int got_addr(input int k);
        if (k < 0 || k >= wa_q.size()) return -1;
        return int'(wa_q[k]);
    endfunction

    task automatic do_reset;
        @(negedge clk);
        rst_n = 1'b0;
        s_valid = 1'b0;
        layer_done = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int w;
        if (abort) return;
        while (int'($urandom_range(99, 0)) < gap) begin
            @(negedge clk);
            s_valid = 1'b0;
        end
        w = 0;
        forever begin
            @(negedge clk);
            s_valid = 1'b1;
            s_data  = b;
            if (s_ready) break;
            w++;
            if (w > 5000) begin
                checks++;
                errors++;
                $display("FAIL handshake_timeout got s_ready=0 want 1");
                abort   = 1'b1;
                s_valid = 1'b0;
                return;
            end
        end
        last_cyc = cyc;
    endtask

    task automatic send_frame(input logic [7:0] cmd, input int plen,
                              input int fill, input int gap,
                              input int delta);
        logic [7:0] sum;
        logic [7:0] b;
        sum = 8'd0;
        pl.delete();
        pay_cyc.delete();
        wa_q.delete();
        wd_q.delete();
        wc_q.delete();
        send_byte(cmd, gap);
        for (int i = 0; i < plen; i++) begin
            b = (fill < 0) ? 8'($urandom) : 8'(fill);
            pl.push_back(b);
            sum = sum + b;
            send_byte(b, gap);
            pay_cyc.push_back(last_cyc);
        end
        send_byte(sum + 8'(delta), gap);
        sum_cyc = last_cyc;
        @(negedge clk);
        s_valid = 1'b0;
    endtask

    task automatic test_reset;
        int d0;
        @(negedge clk);
        rst_n = 1'b0;
        s_valid = 1'b0;
        #1;
        checks++;
        if ({s_ready, mem_we, layer_start, busy, params_valid,
             frame_err, run_done} !== 7'b0) begin
            errors++;
            $display("FAIL reset_flags got %b want 0000000",
                     {s_ready, mem_we, layer_start, busy, params_valid,
                      frame_err, run_done});
        end
        checks++;
        if ({mem_waddr, mem_wdata} !== 22'd0) begin
            errors++;
            $display("FAIL reset_mem_bus got %h/%h want 0/0",
                     mem_waddr, mem_wdata);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        checks++;
        if (s_ready !== 1'b0) begin
            errors++;
            $display("FAIL ready_at_release got %b want 0", s_ready);
        end
        @(negedge clk);
        checks++;
        if (s_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_release got %b want 1", s_ready);
        end
        d0 = n_done;
        layer_done = 1'b1;
        @(negedge clk);
        layer_done = 1'b0;
        @(negedge clk);
        checks++;
        if (n_done !== d0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL stray_done got done=%0d busy=%b want %0d 0",
                     n_done - d0, busy, 0);
        end
    endtask

    task automatic test_params_load;
        int s0, e0, fb;
        s0 = n_start;
        e0 = n_err;
        send_frame(8'hA2, PL, 1, 0, 0);
        repeat (2) @(negedge clk);
        checks++;
        if (wa_q.size() !== PL) begin
            errors++;
            $display("FAIL params_count got %0d want %0d", wa_q.size(), PL);
        end
        fb = first_bad_write(8'hA2);
        checks++;
        if (fb !== -1) begin
            errors++;
            $display("FAIL params_writes idx %0d got addr %0d want %0d",
                     fb, got_addr(fb), exp_addr(8'hA2, fb));
        end
        checks++;
        if (params_valid !== 1'b1) begin
            errors++;
            $display("FAIL params_valid got %b want 1", params_valid);
        end
        checks++;
        if (n_start !== s0 || n_err !== e0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL params_side got start=%0d err=%0d busy=%b want 0 0 0",
                     n_start - s0, n_err - e0, busy);
        end
    endtask

    task automatic test_image_run;
        int s0, d0, fb, viol, dc;
        s0 = n_start;
        d0 = n_done;
        send_frame(8'hA1, N, 2, 0, 0);
        viol = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (s_ready !== 1'b0 || busy !== 1'b1) viol++;
        end
        checks++;
        if (n_start !== s0 + 1 || start_cyc !== sum_cyc + 1) begin
            errors++;
            $display("FAIL img_start got n=%0d cyc=%0d want 1 %0d",
                     n_start - s0, start_cyc, sum_cyc + 1);
        end
        checks++;
        if (viol !== 0) begin
            errors++;
            $display("FAIL img_hold got %0d ready cycles want 0", viol);
        end
        checks++;
        if (wa_q.size() !== N) begin
            errors++;
            $display("FAIL img_count got %0d want %0d", wa_q.size(), N);
        end
        fb = first_bad_write(8'hA1);
        checks++;
        if (fb !== -1) begin
            errors++;
            $display("FAIL img_writes idx %0d got addr %0d want %0d",
                     fb, got_addr(fb), exp_addr(8'hA1, fb));
        end
        layer_done = 1'b1;
        dc = cyc;
        @(negedge clk);
        layer_done = 1'b0;
        @(negedge clk);
        checks++;
        if (n_done !== d0 + 1 || done_cyc !== dc + 1) begin
            errors++;
            $display("FAIL run_done got n=%0d cyc=%0d want 1 %0d",
                     n_done - d0, done_cyc, dc + 1);
        end
        checks++;
        if (s_ready !== 1'b1 || busy !== 1'b0 || n_start !== s0 + 1) begin
            errors++;
            $display("FAIL img_after got ready=%b busy=%b want 1 0",
                     s_ready, busy);
        end
    endtask

    task automatic test_bad_checksum;
        int s0, e0;
        s0 = n_start;
        e0 = n_err;
        send_frame(8'hA2, PL, -1, 0, 1);
        repeat (2) @(negedge clk);
        checks++;
        if (n_err !== e0 + 1 || err_cyc !== sum_cyc + 1) begin
            errors++;
            $display("FAIL bad_sum_err got n=%0d cyc=%0d want 1 %0d",
                     n_err - e0, err_cyc, sum_cyc + 1);
        end
        checks++;
        if (params_valid !== 1'b0 || busy !== 1'b0 || n_start !== s0) begin
            errors++;
            $display("FAIL bad_sum_state got pv=%b busy=%b want 0 0",
                     params_valid, busy);
        end
        checks++;
        if (wa_q.size() !== PL) begin
            errors++;
            $display("FAIL bad_sum_count got %0d want %0d", wa_q.size(), PL);
        end
        send_byte(8'h55, 0);
        @(negedge clk);
        s_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (n_err !== e0 + 2 || busy !== 1'b0 || s_ready !== 1'b1) begin
            errors++;
            $display("FAIL bad_cmd got err=%0d busy=%b ready=%b want 2 0 1",
                     n_err - e0, busy, s_ready);
        end
    endtask

    task automatic test_image_no_params;
        int s0, e0, fb;
        do_reset();
        s0 = n_start;
        e0 = n_err;
        send_frame(8'hA1, N, -1, 0, 0);
        repeat (2) @(negedge clk);
        fb = first_bad_write(8'hA1);
        checks++;
        if (wa_q.size() !== N || fb !== -1) begin
            errors++;
            $display("FAIL nop_writes got n=%0d bad=%0d want %0d -1",
                     wa_q.size(), fb, N);
        end
        checks++;
        if (n_err !== e0 + 1 || err_cyc !== sum_cyc + 1) begin
            errors++;
            $display("FAIL nop_err got n=%0d cyc=%0d want 1 %0d",
                     n_err - e0, err_cyc, sum_cyc + 1);
        end
        checks++;
        if (n_start !== s0 || params_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL nop_state got start=%0d pv=%b busy=%b want 0 0 0",
                     n_start - s0, params_valid, busy);
        end
    endtask

    task automatic test_all_gaps;
        int s0, fb;
        s0 = n_start;
        send_frame(8'hA3, PL + N, -1, 30, 0);
        repeat (2) @(negedge clk);
        checks++;
        if (wa_q.size() !== PL + N) begin
            errors++;
            $display("FAIL all_count got %0d want %0d", wa_q.size(), PL + N);
        end
        fb = first_bad_write(8'hA3);
        checks++;
        if (fb !== -1) begin
            errors++;
            $display("FAIL all_writes idx %0d got addr %0d want %0d",
                     fb, got_addr(fb), exp_addr(8'hA3, fb));
        end
        checks++;
        if (n_start !== s0 + 1 || start_cyc !== sum_cyc + 1) begin
            errors++;
            $display("FAIL all_start got n=%0d cyc=%0d want 1 %0d",
                     n_start - s0, start_cyc, sum_cyc + 1);
        end
        checks++;
        if (params_valid !== 1'b1 || s_ready !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL all_state got pv=%b ready=%b busy=%b want 1 0 1",
                     params_valid, s_ready, busy);
        end
    endtask

    task automatic test_reset_mid;
        int s0, d0, fb;
        s0 = n_start;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({s_ready, mem_we, layer_start, busy, params_valid, frame_err,
             run_done, mem_waddr, mem_wdata} !== 29'd0) begin
            errors++;
            $display("FAIL rst_wait_done got busy=%b pv=%b ready=%b want 0",
                     busy, params_valid, s_ready);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        send_byte(8'hA2, 0);
        for (int i = 0; i < 2000; i++) send_byte(8'($urandom), 0);
        rst_n = 1'b0;
        s_valid = 1'b0;
        #1;
        checks++;
        if ({s_ready, mem_we, layer_start, busy, params_valid, frame_err,
             run_done, mem_waddr, mem_wdata} !== 29'd0) begin
            errors++;
            $display("FAIL rst_weights got busy=%b we=%b addr=%0d want 0",
                     busy, mem_we, mem_waddr);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (n_start !== s0 || busy !== 1'b0 || s_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_after got start=%0d busy=%b ready=%b want 0 0 1",
                     n_start - s0, busy, s_ready);
        end
        send_frame(8'hA2, PL, -1, 0, 0);
        repeat (2) @(negedge clk);
        fb = first_bad_write(8'hA2);
        checks++;
        if (wa_q.size() !== PL || fb !== -1 || params_valid !== 1'b1) begin
            errors++;
            $display("FAIL reload_params got n=%0d bad=%0d pv=%b want %0d -1 1",
                     wa_q.size(), fb, params_valid, PL);
        end
        d0 = n_done;
        send_frame(8'hA1, N, -1, 0, 0);
        repeat (2) @(negedge clk);
        fb = first_bad_write(8'hA1);
        checks++;
        if (wa_q.size() !== N || fb !== -1) begin
            errors++;
            $display("FAIL reload_img got n=%0d bad=%0d want %0d -1",
                     wa_q.size(), fb, N);
        end
        checks++;
        if (n_start !== s0 + 1 || start_cyc !== sum_cyc + 1) begin
            errors++;
            $display("FAIL reload_start got n=%0d cyc=%0d want 1 %0d",
                     n_start - s0, start_cyc, sum_cyc + 1);
        end
        layer_done = 1'b1;
        @(negedge clk);
        layer_done = 1'b0;
        @(negedge clk);
        checks++;
        if (n_done !== d0 + 1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reload_done got n=%0d busy=%b want 1 0",
                     n_done - d0, busy);
        end
    endtask

    initial begin
        test_reset();
        test_params_load();
        test_image_run();
        test_bad_checksum();
        test_image_no_params();
        test_all_gaps();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
